keypad_number_entry: RTL and testbench
======================================

// Module: keypad_number_entry
// PURPOSE
//   Input-side counterpart of the 3-digit 7-segment number display: scans a 4x4 matrix
//   keypad, debounces it and builds a decimal number 0..999 from key presses. Commits the
//   number to the consuming logic over a valid/ack handshake (e.g. as the display value).
// PARAMETERS
//   SCAN_DIV        50000  clk cycles each keypad column is driven (column dwell)
//   DEBOUNCE_SCANS  4      consecutive identical full scans required before a state is stable
// PORTS
//   clk           in   1   system clock; all logic on posedge
//   rst_n         in   1   asynchronous active-low reset
//   kp_row        in   4   keypad rows, active-low (externally pulled up)
//   kp_col        out  4   keypad columns, active-low, exactly one low at a time
//   entry_value   out  10  number being typed (live, for display)
//   entry_digits  out  2   digits typed so far, 0..3
//   key_code      out  4   code of last accepted key
//   key_strobe    out  1   one-cycle pulse per accepted key press
//   num_value     out  10  committed number, stable while num_valid=1
//   num_valid     out  1   committed number available
//   num_ack       in   1   consumer accepts num_value
// BEHAVIOUR
//   Reset (async, rst_n=0): kp_col=4'b1110, entry_value=0, entry_digits=0, key_code=0,
//     key_strobe=0, num_value=0, num_valid=0, scan/debounce/FSM state cleared.
//   Scan: column index c advances 0->1->2->3->0 every SCAN_DIV cycles; kp_col=~(1<<c).
//     kp_row sampled on the last cycle of each dwell; bit[4*r+c] of a 16-bit snapshot = ~kp_row[r].
//     Snapshot complete after column 3.
//   Debounce: snapshot equal to previous snapshot for DEBOUNCE_SCANS consecutive scans ->
//     becomes the stable state; any difference restarts the count.
//   Press detector FSM: RELEASED -> PRESSED when stable state has exactly one bit set;
//     transition emits key_strobe for 1 cycle and updates key_code. PRESSED -> RELEASED only
//     when stable state is all-zero. Multi-key stable state: no event, stays/moves to PRESSED.
//     Held key: no repeat.
//   Key map (row r, col c): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D.
//     key_code: digits = value, A..D = 10..13, * = 14, # = 15.
//   Entry FSM (EMPTY: digits=0, ENTERING: digits>0), updated the cycle after key_strobe:
//     digit: if entry_digits<3, entry_value<=entry_value*10+digit (max 999, 10 bits),
//       entry_digits+1, ->ENTERING; 4th digit ignored. Leading zeros count as digits.
//     A..D: strobed on key_code only, no entry effect.
//     * : see CONFIGURATION.
//     # in EMPTY: ignored. # in ENTERING: if num_valid=0, or num_ack=1 same cycle:
//       num_value<=entry_value, num_valid<=1, entry cleared, ->EMPTY; otherwise
//       (unacked value pending) ignored, entry retained.
//   Handshake: num_valid set by commit, cleared the cycle after num_ack sampled high
//     (unless a commit coincides, then stays 1 with new value). num_ack while num_valid=0 ignored.
//   Latency: stable press -> key_strobe within (DEBOUNCE_SCANS+2)*4*SCAN_DIV cycles;
//     key_strobe -> entry/num outputs updated 1 cycle later.
//   Reset mid-scan or mid-entry: immediate return to reset values; no pending commit survives.
// CONFIGURATION
//   KEYPAD_BACKSPACE_EN defined: * is backspace: entry_value<=entry_value/10,
//     entry_digits-1 (to EMPTY at 0); ignored in EMPTY.
//   Not defined: * clears entry_value and entry_digits to 0, ->EMPTY.
// TESTING (sim with SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model shorts row to driven column)
//   Press 4,2,7,# with no ack -> key_strobe x4, entry 4,42,427, then num_value=427, num_valid=1, entry 0.
//   Hold valid, type 1,#, then num_ack=1 one cycle -> first # ignored (num_value 427, entry 1);
//     valid drops next cycle; second # commits 1.
//   Press 9,9,9,5 -> entry_value=999, entry_digits=3, 5 ignored; 5 and 2 together -> no strobe.
//   Row bouncing every 3 cycles for 40 cycles then steady key 8 -> exactly one key_strobe, code 8.
//   Type 3,6 then *: without macro entry_value=0,digits=0; with KEYPAD_BACKSPACE_EN entry_value=3,digits=1.
//   Assert rst_n=0 mid-entry with num_valid=1 -> all outputs to reset values same time, kp_col=4'b1110.

Source files
------------

// File: rtl/keypad_number_entry.sv
// keypad_number_entry
//   Scans a 4x4 active-low matrix keypad and debounces the full 16-key snapshot.
//   Each new single-key press produces one key_strobe. Digit keys build a decimal number
//   of up to three digits (0..999). '#' commits that number over a valid/ack handshake.
//   Optional feature macro: KEYPAD_BACKSPACE_EN
//     defined     -> '*' deletes the last typed digit
//     not defined -> '*' clears the whole entry
//   The row inputs pass through a two-flop synchronizer, so SCAN_DIV must be at least 3.
//   That keeps each sample inside the dwell of the column it belongs to.

module keypad_number_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kp_row,
    output logic [3:0] kp_col,
    output logic [9:0] entry_value,
    output logic [1:0] entry_digits,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [9:0] num_value,
    output logic       num_valid,
    input  logic       num_ack
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic {KEY_RELEASED = 1'b0, KEY_PRESSED = 1'b1} key_state_t;
    typedef enum logic {ENTRY_EMPTY = 1'b0, ENTRY_ENTERING = 1'b1} entry_state_t;

    // Key position (bit index 4*row+col) to key code.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            4'd15:   code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] first_set(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_r;
    logic [15:0]      snap_acc_r;
    logic [15:0]      snap_next_s;
    logic             sample_s;
    logic             snap_done_s;
    logic [15:0]      prev_snap_r;
    logic [15:0]      stable_r;
    logic [DB_W-1:0]  db_cnt_r;
    logic             one_hot_s;
    key_state_t       key_state_r;
    entry_state_t     entry_state_r;

    assign sample_s    = (div_r == DIV_LAST);
    assign snap_done_s = sample_s && (col_r == 2'd3);
    assign one_hot_s   = (stable_r != 16'd0) && ((stable_r & (stable_r - 16'd1)) == 16'd0);

    // Two-flop synchronizer for the asynchronous keypad rows (idle level is all ones).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= kp_row;
            row_sync_r <= row_meta_r;
        end
    end

    // Snapshot with the current column's pressed-row bits merged in.
    always_comb begin
        snap_next_s = snap_acc_r;
        for (int r = 0; r < 4; r++) begin
            snap_next_s[4*r + int'(col_r)] = ~row_sync_r[r];
        end
    end

    // Column dwell counter, column rotation and snapshot accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r      <= '0;
            col_r      <= 2'd0;
            kp_col     <= 4'b1110;
            snap_acc_r <= 16'd0;
        end else if (sample_s) begin
            div_r      <= '0;
            col_r      <= col_r + 2'd1;
            kp_col     <= {kp_col[2:0], kp_col[3]};
            snap_acc_r <= snap_next_s;
        end else begin
            div_r      <= div_r + DIV_W'(1);
        end
    end

    // Debounce: a snapshot becomes stable after repeating for DEBOUNCE_SCANS comparisons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_snap_r <= 16'd0;
            stable_r    <= 16'd0;
            db_cnt_r    <= '0;
        end else if (snap_done_s) begin
            prev_snap_r <= snap_next_s;
            if (snap_next_s != prev_snap_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                stable_r <= snap_next_s;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end else begin
            prev_snap_r <= prev_snap_r;
        end
    end

    // Press detector: a single new key strobes once; multi-key chords and held keys do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_r <= KEY_RELEASED;
            key_strobe  <= 1'b0;
            key_code    <= 4'd0;
        end else begin
            key_strobe <= 1'b0;
            case (key_state_r)
                KEY_RELEASED: begin
                    if (stable_r != 16'd0) begin
                        key_state_r <= KEY_PRESSED;
                        if (one_hot_s) begin
                            key_strobe <= 1'b1;
                            key_code   <= key_map(first_set(stable_r));
                        end else begin
                            key_code   <= key_code;
                        end
                    end else begin
                        key_state_r <= KEY_RELEASED;
                    end
                end
                KEY_PRESSED: begin
                    if (stable_r == 16'd0) begin
                        key_state_r <= KEY_RELEASED;
                    end else begin
                        key_state_r <= KEY_PRESSED;
                    end
                end
                default: key_state_r <= KEY_RELEASED;
            endcase
        end
    end

    // Entry builder and commit handshake, acting on the strobed key one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_state_r <= ENTRY_EMPTY;
            entry_value   <= 10'd0;
            entry_digits  <= 2'd0;
            num_value     <= 10'd0;
            num_valid     <= 1'b0;
        end else begin
            if (num_valid && num_ack) begin
                num_valid <= 1'b0;
            end else begin
                num_valid <= num_valid;
            end
            if (key_strobe) begin
                if (key_code <= 4'd9) begin
                    if (entry_digits < 2'd3) begin
                        entry_value   <= entry_value * 10'd10 + {6'd0, key_code};
                        entry_digits  <= entry_digits + 2'd1;
                        entry_state_r <= ENTRY_ENTERING;
                    end else begin
                        entry_value   <= entry_value;
                    end
                end else if (key_code == 4'd14) begin
`ifdef KEYPAD_BACKSPACE_EN
                    case (entry_state_r)
                        ENTRY_ENTERING: begin
                            entry_value  <= entry_value / 10'd10;
                            entry_digits <= entry_digits - 2'd1;
                            if (entry_digits == 2'd1) begin
                                entry_state_r <= ENTRY_EMPTY;
                            end else begin
                                entry_state_r <= ENTRY_ENTERING;
                            end
                        end
                        default: entry_state_r <= ENTRY_EMPTY;
                    endcase
`else
                    entry_value   <= 10'd0;
                    entry_digits  <= 2'd0;
                    entry_state_r <= ENTRY_EMPTY;
`endif
                end else if (key_code == 4'd15) begin
                    case (entry_state_r)
                        ENTRY_ENTERING: begin
                            if (!num_valid || num_ack) begin
                                num_value     <= entry_value;
                                num_valid     <= 1'b1;
                                entry_value   <= 10'd0;
                                entry_digits  <= 2'd0;
                                entry_state_r <= ENTRY_EMPTY;
                            end else begin
                                entry_state_r <= ENTRY_ENTERING;
                            end
                        end
                        default: entry_state_r <= ENTRY_EMPTY;
                    endcase
                end else begin
                    entry_state_r <= entry_state_r;
                end
            end else begin
                entry_state_r <= entry_state_r;
            end
        end
    end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Self-checking bench for keypad_number_entry (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// The keypad model shorts a row low while a pressed key's column is driven.
// Expected values come from an arithmetic model of the entry and commit rules.

module tb_keypad_number_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic [9:0] entry_value;
    logic [1:0] entry_digits;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [9:0] num_value;
    logic       num_valid;
    logic       num_ack;
    logic [15:0] pressed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_val, m_dig, m_num, m_valid, m_code;

    // Key codes by position 4*row+col, from the keypad legend.
    int key_at[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_number_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .kp_row(kp_row), .kp_col(kp_col),
        .entry_value(entry_value), .entry_digits(entry_digits), .key_code(key_code),
        .key_strobe(key_strobe), .num_value(num_value), .num_valid(num_valid),
        .num_ack(num_ack)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !kp_col[c]) kp_row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int code);
        for (int i = 0; i < 16; i++) if (key_at[i] == code) return i;
        return 0;
    endfunction

    // Model update for one accepted key, with num_ack high in that same cycle.
    task automatic model_key(input int code, input int ack);
        int committed;
        committed = 0;
        m_code = code;
        if (code <= 9) begin
            if (m_dig < 3) begin m_val = m_val * 10 + code; m_dig++; end
        end else if (code == 14) begin
`ifdef KEYPAD_BACKSPACE_EN
            if (m_dig > 0) begin m_val = m_val / 10; m_dig--; end
`else
            m_val = 0; m_dig = 0;
`endif
        end else if (code == 15) begin
            if (m_dig > 0 && (m_valid == 0 || ack != 0)) begin
                m_num = m_val; m_valid = 1; m_val = 0; m_dig = 0; committed = 1;
            end
        end
        if (ack != 0 && committed == 0) m_valid = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".entry_value"}, 32'(entry_value), 32'(m_val));
        check({tag, ".entry_digits"}, 32'(entry_digits), 32'(m_dig));
        check({tag, ".num_valid"}, 32'(num_valid), 32'(m_valid));
        if (m_valid != 0) check({tag, ".num_value"}, 32'(num_value), 32'(m_num));
    endtask

    // Release everything and confirm no further strobes while releasing.
    task automatic release_all(input string tag, input int extra_in);
        int extra;
        extra = extra_in;
        pressed = 16'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_strobe) extra++;
        end
        check({tag, ".no_repeat"}, 32'(extra), 32'd0);
    endtask

    task automatic press_key(input int code, input int ack);
        int seen, extra;
        string tag;
        tag = $sformatf("key%0d", code);
        seen = 0;
        extra = 0;
        pressed[pos_of(code)] = 1'b1;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (key_strobe) seen = 1;
        end
        check({tag, ".strobe"}, 32'(seen), 32'd1);
        if (seen != 0) begin
            check({tag, ".code"}, 32'(key_code), 32'(code));
            num_ack = (ack != 0);
            @(negedge clk);
            num_ack = 1'b0;
            model_key(code, ack);
            check_outputs(tag);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_strobe) extra++;
        end
        release_all(tag, extra);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        num_ack = 1'b1;
        @(negedge clk);
        num_ack = 1'b0;
        m_valid = 0;
        check("ack.num_valid", 32'(num_valid), 32'd0);
    endtask

    initial begin
        int strobes;
        int code;
        rst_n = 1'b0;
        num_ack = 1'b0;
        pressed = 16'd0;
        m_val = 0; m_dig = 0; m_num = 0; m_valid = 0; m_code = 0;
        repeat (2) @(negedge clk);
        check("rst.kp_col", 32'(kp_col), 32'hE);
        check("rst.key_code", 32'(key_code), 32'd0);
        check("rst.key_strobe", 32'(key_strobe), 32'd0);
        check("rst.num_value", 32'(num_value), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;

        // Column scan sequence: one column per 4-cycle dwell, rotating through all four.
        for (int k = 0; k < 20; k++) begin
            logic [3:0] one;
            one = 4'b0001;
            check($sformatf("scan%0d", k), 32'(kp_col), 32'(4'b1111 ^ (one << ((k / 4) % 4))));
            @(negedge clk);
        end

        // 4,2,7,# without ack commits 427.
        press_key(4, 0); press_key(2, 0); press_key(7, 0); press_key(15, 0);
        // Pending value blocks the first #; after ack the second # commits 1.
        press_key(1, 0); press_key(15, 0);
        ack_pulse();
        press_key(15, 0);
        ack_pulse();
        // Three digits maximum, fourth ignored.
        press_key(9, 0); press_key(9, 0); press_key(9, 0); press_key(5, 0);

        // Two keys at once: no strobe, key_code unchanged.
        strobes = 0;
        pressed[pos_of(5)] = 1'b1;
        pressed[pos_of(2)] = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (key_strobe) strobes++;
        end
        check("chord.strobes", 32'(strobes), 32'd0);
        check("chord.key_code", 32'(key_code), 32'(m_code));
        check_outputs("chord");
        release_all("chord", 0);

        // Commit 999 with ack in the same cycle as the #.
        press_key(15, 1);
        ack_pulse();

        // Bouncing key 8, then held steady: exactly one strobe.
        strobes = 0;
        code = -1;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[pos_of(8)] = ~pressed[pos_of(8)];
            @(negedge clk);
            if (key_strobe) begin strobes++; code = int'(key_code); end
        end
        pressed[pos_of(8)] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_strobe) begin strobes++; code = int'(key_code); end
        end
        check("bounce.strobes", 32'(strobes), 32'd1);
        check("bounce.code", 32'(code), 32'd8);
        model_key(8, 0);
        check_outputs("bounce");
        release_all("bounce", 0);

        // '*' behaviour: clear/backspace depending on the build.
        press_key(14, 0);
        press_key(3, 0); press_key(6, 0); press_key(14, 0);

        // Randomized key sequence against the model.
        for (int n = 0; n < 25; n++) begin
            int k, a;
            k = int'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 1 : 0;
            press_key(k, a);
            if ($urandom_range(0, 5) == 0) ack_pulse();
        end

        // Reset in the middle of an entry with a committed value pending.
        ack_pulse();
        press_key(5, 0); press_key(15, 0); press_key(3, 0);
        check("prerst.num_valid", 32'(num_valid), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.kp_col", 32'(kp_col), 32'hE);
        check("midrst.entry_value", 32'(entry_value), 32'd0);
        check("midrst.entry_digits", 32'(entry_digits), 32'd0);
        check("midrst.key_code", 32'(key_code), 32'd0);
        check("midrst.key_strobe", 32'(key_strobe), 32'd0);
        check("midrst.num_value", 32'(num_value), 32'd0);
        check("midrst.num_valid", 32'(num_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 0; m_dig = 0; m_valid = 0; m_num = 0;
        repeat (3) @(negedge clk);
        check_outputs("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
